// File: rtl/alarm_controller.sv
// alarm_controller: arming/alarm state machine in front of the 9-bit delay
// counter. Drives the counter's reset/enable/load, watches its value to time
// the exit and entry delays, and produces siren and status outputs.
module alarm_controller #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned EXIT_TICKS  = 30,
    parameter int unsigned ENTRY_TICKS = 20,
    parameter int unsigned NSENS       = 4
) (
    input  logic             clock50,
    input  logic             Mr,
    input  logic             arm,
    input  logic             disarm,
    input  logic             sensor_door,
    input  logic [NSENS-1:0] sensor_inst,
    input  logic [8:0]       timer_q,
    output logic             timer_mr,
    output logic             timer_en,
    output logic             timer_load,
    output logic [8:0]       timer_value,
    output logic             siren,
    output logic             armed,
    output logic             arm_fault,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4
    } state_t;

    // Counter preload values: the counter reaches 511 on the last tick.
    localparam logic [8:0]  EXIT_LOAD  = 9'(512 - EXIT_TICKS);
    localparam logic [8:0]  ENTRY_LOAD = 9'(512 - ENTRY_TICKS);
    localparam logic [25:0] TICK_MAX   = 26'(TICK_DIV - 1);

    state_t      cur_state;
    state_t      next_state;
    logic [25:0] prescale;
    logic        in_delay;
    logic        tick;
    logic        expire;
    logic        trip_any;
    logic        inst_trip;
    logic        load_next;
    logic        fault_next;

    assign inst_trip = |sensor_inst;
    assign trip_any  = sensor_door | inst_trip;
    assign in_delay  = (cur_state == EXIT_DELAY) || (cur_state == ENTRY_DELAY);
    assign tick      = in_delay & ~timer_load & (prescale == TICK_MAX);
    assign expire    = timer_en & (timer_q == 9'd511);

    // Next-state logic; disarm overrides every other condition.
    always_comb begin
        next_state = cur_state;
        if (disarm) begin
            next_state = DISARMED;
        end else begin
            case (cur_state)
                DISARMED: begin
                    if (arm && !trip_any) next_state = EXIT_DELAY;
                end
                EXIT_DELAY: begin
                    if (expire) next_state = ARMED;
                end
                ARMED: begin
                    if (inst_trip)        next_state = ALARM;
                    else if (sensor_door) next_state = ENTRY_DELAY;
                end
                ENTRY_DELAY: begin
                    if (inst_trip || expire) next_state = ALARM;
                end
                ALARM: begin
                    next_state = ALARM;
                end
                default: begin
                    next_state = DISARMED;
                end
            endcase
        end
    end

    // Load flag and arm-refusal pulse are decided one cycle ahead.
    always_comb begin
        load_next  = 1'b0;
        fault_next = 1'b0;
        if ((next_state == EXIT_DELAY && cur_state != EXIT_DELAY) ||
            (next_state == ENTRY_DELAY && cur_state != ENTRY_DELAY)) begin
            load_next = 1'b1;
        end
        if (cur_state == DISARMED && !disarm && arm && trip_any) begin
            fault_next = 1'b1;
        end
    end

    // State register and registered control flags.
    always_ff @(posedge clock50 or posedge Mr) begin
        if (Mr) begin
            cur_state  <= DISARMED;
            timer_load <= 1'b0;
            arm_fault  <= 1'b0;
        end else begin
            cur_state  <= next_state;
            timer_load <= load_next;
            arm_fault  <= fault_next;
        end
    end

    // Tick prescaler: idle outside delays and during the load cycle.
    always_ff @(posedge clock50 or posedge Mr) begin
        if (Mr) begin
            prescale <= '0;
        end else if (!in_delay || timer_load) begin
            prescale <= '0;
        end else if (prescale == TICK_MAX) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 26'd1;
        end
    end

    // Output decode from the current state.
    always_comb begin
        timer_mr    = 1'b0;
        siren       = 1'b0;
        armed       = 1'b0;
        timer_value = '0;
        timer_en    = tick;
        case (cur_state)
            DISARMED:    timer_mr    = 1'b1;
            EXIT_DELAY:  timer_value = EXIT_LOAD;
            ARMED:       armed       = 1'b1;
            ENTRY_DELAY: begin
                armed       = 1'b1;
                timer_value = ENTRY_LOAD;
            end
            ALARM:       siren       = 1'b1;
            default:     timer_mr    = 1'b0;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller with a behavioural 9-bit delay counter attached.
module tb_alarm_controller;

    logic       clock50 = 1'b0;
    logic       Mr;
    logic       arm;
    logic       disarm;
    logic       sensor_door;
    logic [3:0] sensor_inst;
    logic [8:0] timer_q;
    logic       timer_mr;
    logic       timer_en;
    logic       timer_load;
    logic [8:0] timer_value;
    logic       siren;
    logic       armed;
    logic       arm_fault;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    logic race_on   = 1'b0;
    logic siren_hit = 1'b0;

    alarm_controller #(
        .TICK_DIV   (4),
        .EXIT_TICKS (3),
        .ENTRY_TICKS(2),
        .NSENS      (4)
    ) dut (
        .clock50    (clock50),
        .Mr         (Mr),
        .arm        (arm),
        .disarm     (disarm),
        .sensor_door(sensor_door),
        .sensor_inst(sensor_inst),
        .timer_q    (timer_q),
        .timer_mr   (timer_mr),
        .timer_en   (timer_en),
        .timer_load (timer_load),
        .timer_value(timer_value),
        .siren      (siren),
        .armed      (armed),
        .arm_fault  (arm_fault),
        .state      (state)
    );

    always #5 clock50 = ~clock50;

    // Delay counter: async clear, load over count-enable.
    always @(posedge clock50 or posedge timer_mr) begin
        if (timer_mr)        timer_q <= '0;
        else if (timer_load) timer_q <= timer_value;
        else if (timer_en)   timer_q <= timer_q + 9'd1;
    end

    // Latch any siren activity during the disarm race.
    always @(negedge clock50) begin
        if (race_on && siren) siren_hit <= 1'b1;
    end

    typedef struct {
        logic       a;
        logic       d;
        logic       door;
        logic [3:0] inst;
        logic [2:0] st;
        logic       armd;
        logic       sir;
        logic       flt;
        logic       ld;
        logic       en;
        logic       mr;
        logic [8:0] val;
    } vec_t;

    vec_t vecs [30];

    function automatic vec_t mk(input logic a, input logic d, input logic door,
                                input logic [3:0] inst, input logic [2:0] st,
                                input logic armd, input logic sir, input logic flt,
                                input logic ld, input logic en, input logic [8:0] val);
        vec_t v;
        v.a = a; v.d = d; v.door = door; v.inst = inst;
        v.st = st; v.armd = armd; v.sir = sir; v.flt = flt;
        v.ld = ld; v.en = en; v.val = val;
        v.mr = (st == 3'd0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock50);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
        int n = 0;
        while (state !== tgt && n < budget) begin
            step();
            n++;
        end
        chk(name, {29'd0, state}, {29'd0, tgt});
    endtask

    initial begin
        logic found;

        // cycle-by-cycle: arm/exit, entry timeout, alarm, disarm, arm refused
        vecs[0]  = mk(1,0,0,4'h0, 1, 0,0,0,1,0,9'd509);
        vecs[1]  = mk(0,0,0,4'h0, 1, 0,0,0,0,0,9'd509);
        vecs[2]  = mk(0,0,0,4'h0, 1, 0,0,0,0,0,9'd509);
        vecs[3]  = mk(0,0,0,4'h0, 1, 0,0,0,0,0,9'd509);
        vecs[4]  = mk(0,0,0,4'h0, 1, 0,0,0,0,1,9'd509);
        vecs[5]  = mk(0,0,1,4'h1, 1, 0,0,0,0,0,9'd509);
        vecs[6]  = mk(0,0,1,4'h1, 1, 0,0,0,0,0,9'd509);
        vecs[7]  = mk(0,0,0,4'h0, 1, 0,0,0,0,0,9'd509);
        vecs[8]  = mk(0,0,0,4'h0, 1, 0,0,0,0,1,9'd509);
        vecs[9]  = mk(0,0,0,4'h0, 1, 0,0,0,0,0,9'd509);
        vecs[10] = mk(0,0,0,4'h0, 1, 0,0,0,0,0,9'd509);
        vecs[11] = mk(0,0,0,4'h0, 1, 0,0,0,0,0,9'd509);
        vecs[12] = mk(0,0,0,4'h0, 1, 0,0,0,0,1,9'd509);
        vecs[13] = mk(0,0,0,4'h0, 2, 1,0,0,0,0,9'd0);
        vecs[14] = mk(0,0,1,4'h0, 3, 1,0,0,1,0,9'd510);
        vecs[15] = mk(0,0,0,4'h0, 3, 1,0,0,0,0,9'd510);
        vecs[16] = mk(0,0,0,4'h0, 3, 1,0,0,0,0,9'd510);
        vecs[17] = mk(0,0,0,4'h0, 3, 1,0,0,0,0,9'd510);
        vecs[18] = mk(0,0,0,4'h0, 3, 1,0,0,0,1,9'd510);
        vecs[19] = mk(0,0,0,4'h0, 3, 1,0,0,0,0,9'd510);
        vecs[20] = mk(0,0,0,4'h0, 3, 1,0,0,0,0,9'd510);
        vecs[21] = mk(0,0,0,4'h0, 3, 1,0,0,0,0,9'd510);
        vecs[22] = mk(0,0,0,4'h0, 3, 1,0,0,0,1,9'd510);
        vecs[23] = mk(0,0,0,4'h0, 4, 0,1,0,0,0,9'd0);
        vecs[24] = mk(1,0,0,4'h0, 4, 0,1,0,0,0,9'd0);
        vecs[25] = mk(0,1,0,4'h0, 0, 0,0,0,0,0,9'd0);
        vecs[26] = mk(0,0,0,4'h0, 0, 0,0,0,0,0,9'd0);
        vecs[27] = mk(1,0,0,4'h2, 0, 0,0,1,0,0,9'd0);
        vecs[28] = mk(1,0,0,4'h2, 0, 0,0,1,0,0,9'd0);
        vecs[29] = mk(0,0,0,4'h0, 0, 0,0,0,0,0,9'd0);

        Mr = 1'b1; arm = 1'b0; disarm = 1'b0; sensor_door = 1'b0; sensor_inst = 4'h0;
        repeat (2) @(posedge clock50);
        #1 Mr = 1'b0;

        // Arm, then hit Mr mid-cycle while in the exit delay.
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        chk("pre_reset_state", {29'd0, state}, 32'd1);
        #3 Mr = 1'b1;
        #1;
        chk("rst_state",  {29'd0, state}, 32'd0);
        chk("rst_mr",     {31'd0, timer_mr}, 32'd1);
        chk("rst_siren",  {31'd0, siren}, 32'd0);
        chk("rst_armed",  {31'd0, armed}, 32'd0);
        chk("rst_en",     {31'd0, timer_en}, 32'd0);
        chk("rst_load",   {31'd0, timer_load}, 32'd0);
        chk("rst_value",  {23'd0, timer_value}, 32'd0);
        chk("rst_fault",  {31'd0, arm_fault}, 32'd0);
        @(posedge clock50);
        #1 Mr = 1'b0;
        step();

        for (int i = 0; i < 30; i++) begin
            arm = vecs[i].a; disarm = vecs[i].d;
            sensor_door = vecs[i].door; sensor_inst = vecs[i].inst;
            step();
            chk($sformatf("row%0d", i),
                {14'd0, state, armed, siren, arm_fault, timer_load, timer_en, timer_mr, timer_value},
                {14'd0, vecs[i].st, vecs[i].armd, vecs[i].sir, vecs[i].flt,
                 vecs[i].ld, vecs[i].en, vecs[i].mr, vecs[i].val});
        end
        arm = 1'b0; disarm = 1'b0; sensor_door = 1'b0; sensor_inst = 4'h0;

        // Disarm in the same cycle as entry-delay expiry.
        arm = 1'b1;
        step();
        arm = 1'b0;
        wait_state(3'd2, 40, "race_armed");
        sensor_door = 1'b1;
        step();
        sensor_door = 1'b0;
        chk("race_entry", {29'd0, state}, 32'd3);
        race_on = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (timer_en && timer_q == 9'd511) found = 1'b1;
            else step();
        end
        chk("race_expire_seen", {31'd0, found}, 32'd1);
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        chk("race_state", {29'd0, state}, 32'd0);
        chk("race_mr",    {31'd0, timer_mr}, 32'd1);
        step();
        race_on = 1'b0;
        chk("race_no_siren", {31'd0, siren_hit}, 32'd0);

        // Instant-zone trip while armed.
        arm = 1'b1;
        step();
        arm = 1'b0;
        wait_state(3'd2, 40, "inst_armed");
        sensor_inst = 4'b1000;
        step();
        sensor_inst = 4'h0;
        chk("inst_state", {29'd0, state}, 32'd4);
        chk("inst_siren", {31'd0, siren}, 32'd1);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("alarm_arm_ignored", {29'd0, state}, 32'd4);
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        chk("alarm_disarm_state", {29'd0, state}, 32'd0);
        chk("alarm_disarm_mr",    {31'd0, timer_mr}, 32'd1);
        chk("alarm_disarm_siren", {31'd0, siren}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Arming/alarm state machine for the alarm system. It sits directly upstream of the team's 9-bit delay counter (Ninebitcounter) and drives that counter's master reset, enable, load and load value. It reads back the counter value to time the exit and entry delays. It also generates the siren and status outputs from arm/disarm commands and sensor inputs.

## Interface
- TICK_DIV, 50_000_000: clock50 cycles per delay tick; legal range 2..2^26 (prescaler is 26 bits).
- EXIT_TICKS, 30: exit-delay length in ticks; legal range 1..511.
- ENTRY_TICKS, 20: entry-delay length in ticks; legal range 1..511.
- NSENS, 4: number of instant-zone sensors.
- clock50  input  1  system clock; all state changes on its rising edge.
- Mr  input  1  master reset; asynchronous, active-high.
- arm  input  1  arm request; synchronous level, sampled every cycle.
- disarm  input  1  valid-code/disarm; synchronous level; highest priority.
- sensor_door  input  1  entry-zone sensor (delayed); 1 = tripped.
- sensor_inst  input  NSENS  instant-zone sensors; any bit 1 = tripped.
- timer_q  input  9  current counter value (counter Qout).
- timer_mr  output  1  counter master reset.
- timer_en  output  1  counter enable; one-cycle tick pulse.
- timer_load  output  1  counter load enable.
- timer_value  output  9  counter load value.
- siren  output  1  alarm sounder.
- armed  output  1  system armed indicator.
- arm_fault  output  1  one-cycle pulse: arm refused.
- state  output  3  current state encoding.

## Operation
- States and encodings: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4. Codes 5-7 are unreachable and return to DISARMED on the next edge.
- `trip_any` = sensor_door | (|sensor_inst). `expire` = timer_en & (timer_q == 511), evaluated only in the delay states.
- From any state except DISARMED, disarm → DISARMED. This has priority over every other condition in the same cycle.
- DISARMED:
  - arm & ~trip_any → EXIT_DELAY.
  - arm & trip_any → remain DISARMED; arm_fault=1 for the next cycle only, repeating each cycle arm stays high.
- EXIT_DELAY: expire → ARMED. Sensors are ignored.
- ARMED:
  - |sensor_inst → ALARM.
  - Otherwise sensor_door → ENTRY_DELAY.
- ENTRY_DELAY:
  - |sensor_inst → ALARM.
  - Otherwise expire → ALARM.
- ALARM: left only by disarm. arm is ignored.
- Output decode:
  - timer_mr=1 only in DISARMED.
  - siren=1 only in ALARM.
  - armed=1 in ARMED and ENTRY_DELAY.
  - timer_value = 512−EXIT_TICKS in EXIT_DELAY, 512−ENTRY_TICKS in ENTRY_DELAY, 0 elsewhere (9-bit, computed at elaboration).
- timer_load is a registered flag. It is 1 for exactly the first cycle spent in EXIT_DELAY or ENTRY_DELAY, and 0 otherwise.
- Prescaler (26-bit):
  - Held at 0 outside the delay states and while timer_load=1; otherwise increments.
  - Tick when count == TICK_DIV−1; count wraps to 0 on the same edge.
- timer_en = tick & in-delay-state & ~timer_load.
- Reset (async, Mr=1): state=DISARMED, prescaler=0, timer_load=0, arm_fault=0. Output values during and after reset: timer_mr=1, timer_en=0, timer_value=0, siren=0, armed=0, state=0.

## Timing
- All transitions take effect one clock50 edge after the condition is sampled.
- disarm→DISARMED latency is 1 cycle from any state.
- Cycle 0 is the first cycle in a delay state; it is the load cycle.
  - Tick k occurs in cycle k·TICK_DIV.
  - The counter holds 512−N+(k−1) before tick k, so tick N sees timer_q=511.
  - The next state is entered at cycle N·TICK_DIV+1, where N = EXIT_TICKS or ENTRY_TICKS.
- The expire edge coincides with the counter's own wrap to 0. No extra timer_en is issued after expiry.
- A sensor and expire in the same ENTRY_DELAY cycle both → ALARM (no conflict).
- disarm and expire in the same cycle → DISARMED.
- Mr asserted mid-delay returns to DISARMED immediately (asynchronously). timer_mr then clears the counter.
- Counter Tc is not used; expiry is determined solely from timer_q.

## Test plan
- Use TICK_DIV=4, EXIT_TICKS=3, ENTRY_TICKS=2, NSENS=4, with this block wired to Ninebitcounter.
- Reset: Mr=1 mid-cycle → state=0, timer_mr=1, siren=0, armed=0, timer_en=0 without waiting for a clock edge.
- Arm/exit:
  - 1-cycle arm with sensors clear → state=1.
  - timer_load=1 with timer_value=509 for one cycle; timer_en pulses at cycles 4, 8 and 12.
  - timer_q=511 before the third pulse; state=2 and armed=1 at cycle 13.
- Arm refused: sensor_inst=4'b0010 with arm=1 for 2 cycles → state stays 0 and arm_fault pulses in 2 consecutive cycles.
- Entry timeout: from ARMED, sensor_door=1 → state=3 with timer_value=510; with no disarm, state=4 and siren=1 at cycle 9.
- Disarm race: in ENTRY_DELAY, drive disarm=1 in the cycle where timer_en=1 and timer_q=511 → state=0 next cycle, siren never asserts.
- Instant trip: in ARMED, sensor_inst=4'b1000 → state=4 next cycle. arm=1 in ALARM has no effect; disarm=1 → state=0 and timer_mr=1.
